mem_mch_ctrl: RTL and testbench

- Parametrised multi-channel successor to the single-channel memory block: NUM_CH independent valid/ready request ports share one DEPTH x MEM_WIDTH single-port memory array.
- A round-robin arbiter accepts at most one request per cycle.
- Writes support byte enables.
- Every accepted transaction returns a response (read data or write ack, plus error flag) on its own channel after a fixed, parametrised latency.
- Sits between per-channel UVM agents/masters and on-chip storage.

---
 rtl/mem_mch_ctrl.sv | 117 +++++++++++
 tb/tb_mem_mch_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_mch_ctrl.sv
// mem_mch_ctrl: round-robin multi-channel access to a shared byte-maskable memory with fixed-latency responses
module mem_mch_ctrl #(
    parameter int NUM_CH     = 2,
    parameter int MEM_WIDTH  = 32,
    parameter int DEPTH      = 48,
    parameter int ADDR_WIDTH = 6,
    parameter int RD_LAT     = 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_CH-1:0]                valid_i,
    input  logic [NUM_CH-1:0]                wr_rd_en_i,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]     addr_i,
    input  logic [NUM_CH*MEM_WIDTH-1:0]      wdata_i,
    input  logic [NUM_CH*(MEM_WIDTH/8)-1:0]  be_i,
    output logic [NUM_CH-1:0]                ready_o,
    output logic [NUM_CH-1:0]                resp_valid_o,
    output logic [NUM_CH*MEM_WIDTH-1:0]      rdata_o,
    output logic [NUM_CH-1:0]                err_o
);
    localparam int NB = MEM_WIDTH / 8;
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PW = 1 + CW + MEM_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    logic [MEM_WIDTH-1:0]  mem [DEPTH];
    logic [CW-1:0]         last_q;
    logic [CW-1:0]         gnt;
    logic [CW-1:0]         idx;
    logic                  acc;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic                  s_wr;
    logic [MEM_WIDTH-1:0]  s_wdata;
    logic [NB-1:0]         s_be;
    logic                  in_rng;
    logic [PW-1:0]         in_e;
    logic [PW-1:0]         tail;
    logic                  t_v;
    logic [CW-1:0]         t_ch;
    logic [MEM_WIDTH-1:0]  t_d;
    logic                  t_e;

    // Grant the first requester found after the last granted channel; nothing is granted in reset
    always_comb begin
        ready_o = '0;
        gnt     = last_q;
        acc     = 1'b0;
        idx     = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = CW'((int'(last_q) + i) % NUM_CH);
            if (rst_i && !acc && valid_i[idx]) begin
                acc          = 1'b1;
                gnt          = idx;
                ready_o[idx] = 1'b1;
            end
        end
    end

    assign s_addr  = addr_i[gnt*ADDR_WIDTH +: ADDR_WIDTH];
    assign s_wr    = wr_rd_en_i[gnt];
    assign s_wdata = wdata_i[gnt*MEM_WIDTH +: MEM_WIDTH];
    assign s_be    = be_i[gnt*NB +: NB];
    assign in_rng  = {1'b0, s_addr} < DEPTH_W;
    assign in_e    = {acc, gnt, (!s_wr && in_rng) ? mem[s_addr] : {MEM_WIDTH{1'b0}}, !in_rng};

    // Byte-masked write on acceptance; out-of-range addresses leave memory untouched
    always_ff @(posedge clk_i) begin
        if (acc && s_wr && in_rng)
            for (int k = 0; k < NB; k++)
                if (s_be[k]) mem[s_addr][k*8 +: 8] <= s_wdata[k*8 +: 8];
    end

    // Remember the last granted channel so channel 0 leads after reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) last_q <= CW'(NUM_CH - 1);
        else if (acc) last_q <= gnt;
    end

    generate
        if (RD_LAT == 1) begin : g_bypass
            assign tail = in_e;
        end else begin : g_pipe
            logic [PW-1:0] st [RD_LAT-1];
            // Delay line of {valid, channel, data, err} ahead of the output register
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    for (int i = 0; i < RD_LAT - 1; i++) st[i] <= '0;
                end else begin
                    st[0] <= in_e;
                    for (int i = 1; i < RD_LAT - 1; i++) st[i] <= st[i-1];
                end
            end
            assign tail = st[RD_LAT-2];
        end
    endgenerate

    assign t_v  = tail[PW-1];
    assign t_ch = tail[PW-2 -: CW];
    assign t_d  = tail[MEM_WIDTH:1];
    assign t_e  = tail[0];

    // Final response stage: pulse the owning channel, hold data/err until its next response
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            resp_valid_o <= '0;
            rdata_o      <= '0;
            err_o        <= '0;
        end else begin
            resp_valid_o <= '0;
            if (t_v) begin
                resp_valid_o[t_ch]                     <= 1'b1;
                rdata_o[t_ch*MEM_WIDTH +: MEM_WIDTH]   <= t_d;
                err_o[t_ch]                            <= t_e;
            end
        end
    end
endmodule

// File: tb/tb_mem_mch_ctrl.sv
// tb_mem_mch_ctrl: randomized and directed checks of two latency variants against a transaction-level model
module tb_mem_mch_ctrl;
    localparam int NC  = 2;
    localparam int W   = 32;
    localparam int D   = 48;
    localparam int AW  = 6;
    localparam int NBY = 4;

    typedef struct {
        int          due;
        int          ch;
        logic [W-1:0] d;
        logic        e;
    } rsp_t;

    logic              clk_i = 1'b0;
    logic              rst_n = 1'b0;
    logic [NC-1:0]     valid = '0;
    logic [NC-1:0]     wr    = '0;
    logic [NC*AW-1:0]  addr  = '0;
    logic [NC*W-1:0]   wdata = '0;
    logic [NC*NBY-1:0] be    = '0;
    logic [NC-1:0]     ready_a, ready_b, rv_a, rv_b, err_a, err_b;
    logic [NC*W-1:0]   rd_a, rd_b;
    logic [NC-1:0]     rdy_s;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cnt_b0 = 0;
    int n0;
    rsp_t qa[$];
    rsp_t qb[$];
    logic [W-1:0] mm [D];
    int mptr = NC - 1;
    logic [NC*W-1:0] hrd_a = '0, hrd_b = '0;
    logic [NC-1:0]   her_a = '0, her_b = '0;
    logic [NC-1:0]   seq [8];

    always #5 clk_i = ~clk_i;

    mem_mch_ctrl #(.NUM_CH(NC), .MEM_WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .RD_LAT(2)) dut_a (
        .clk_i(clk_i), .rst_i(rst_n), .valid_i(valid), .wr_rd_en_i(wr), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .ready_o(ready_a), .resp_valid_o(rv_a), .rdata_o(rd_a), .err_o(err_a)
    );

    mem_mch_ctrl #(.NUM_CH(NC), .MEM_WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .RD_LAT(1)) dut_b (
        .clk_i(clk_i), .rst_i(rst_n), .valid_i(valid), .wr_rd_en_i(wr), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .ready_o(ready_b), .resp_valid_o(rv_b), .rdata_o(rd_b), .err_o(err_b)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Model: each negedge checks outputs, then predicts the acceptance at the coming posedge
    always @(negedge clk_i) begin
        logic [NC-1:0] er, ev;
        int g, c, a;
        rsp_t r;
        er = '0; ev = '0; g = -1; c = 0; a = 0;
        if (!rst_n) begin
            mptr = NC - 1;
            qa.delete();
            qb.delete();
            hrd_a = '0; hrd_b = '0; her_a = '0; her_b = '0;
        end else begin
            for (int i = 1; i <= NC; i++) begin
                c = (mptr + i) % NC;
                if (g < 0 && valid[c]) g = c;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        chk("ready_a", 64'(ready_a), 64'(er));
        chk("ready_b", 64'(ready_b), 64'(er));
        if (qa.size() > 0 && qa[0].due == cyc) begin
            r = qa.pop_front();
            ev[r.ch] = 1'b1;
            hrd_a[r.ch*W +: W] = r.d;
            her_a[r.ch] = r.e;
        end
        chk("resp_valid_a", 64'(rv_a), 64'(ev));
        chk("rdata_a", rd_a, hrd_a);
        chk("err_a", 64'(err_a), 64'(her_a));
        ev = '0;
        if (qb.size() > 0 && qb[0].due == cyc) begin
            r = qb.pop_front();
            ev[r.ch] = 1'b1;
            hrd_b[r.ch*W +: W] = r.d;
            her_b[r.ch] = r.e;
        end
        chk("resp_valid_b", 64'(rv_b), 64'(ev));
        chk("rdata_b", rd_b, hrd_b);
        chk("err_b", 64'(err_b), 64'(her_b));
        if (rv_b[0]) cnt_b0++;
        if (g >= 0) begin
            a    = int'(addr[g*AW +: AW]);
            r.ch = g;
            r.e  = (a >= D);
            r.d  = (!wr[g] && a < D) ? mm[a] : '0;
            r.due = cyc + 2;
            qa.push_back(r);
            r.due = cyc + 1;
            qb.push_back(r);
            if (wr[g] && a < D)
                for (int k = 0; k < NBY; k++)
                    if (be[g*NBY + k]) mm[a][k*8 +: 8] = wdata[g*W + k*8 +: 8];
            mptr = g;
        end
        cyc++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input int ch, input bit w, input int a, input logic [31:0] d, input logic [3:0] b);
        int n;
        valid[ch] = 1'b1;
        wr[ch] = w;
        addr[ch*AW +: AW] = 6'(a);
        wdata[ch*W +: W] = d;
        be[ch*NBY +: NBY] = b;
        n = 0;
        @(negedge clk_i);
        while (!ready_a[ch] && n < 20) begin
            n++;
            @(negedge clk_i);
        end
        chk("grant_wait", 64'(n < 20), 64'(1));
        @(posedge clk_i);
        #1;
        valid[ch] = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        rst_n = 1'b1;
        chk("reset_rv", 64'(rv_a), 64'(0));
        chk("reset_rdata", rd_a, 64'(0));
        for (int a = 0; a < D; a++) issue(a % 2, 1'b1, a, $urandom, 4'hF);
        issue(0, 1'b1, 5, 32'hDEADBEEF, 4'hF);
        wait_cyc(3);
        chk("wack_rdata", 64'(rd_a[31:0]), 64'(0));
        chk("wack_err", 64'(err_a[0]), 64'(0));
        issue(0, 1'b1, 5, 32'hDEADBEEF, 4'hF);
        issue(0, 1'b0, 5, 32'h0, 4'h0);
        wait_cyc(3);
        chk("rd5_a", 64'(rd_a[31:0]), 64'hDEADBEEF);
        chk("rd5_b", 64'(rd_b[31:0]), 64'hDEADBEEF);
        chk("model_mm5", 64'(mm[5]), 64'hDEADBEEF);
        issue(1, 1'b0, 9, 32'h0, 4'h0);
        valid = 2'b11;
        wr = 2'b00;
        addr = {6'd2, 6'd1};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            seq[i] = ready_a;
        end
        @(posedge clk_i);
        #1;
        valid = 2'b00;
        for (int i = 0; i < 8; i++) chk("alternate", 64'(seq[i]), (i % 2 == 1) ? 64'h2 : 64'h1);
        issue(0, 1'b1, 3, 32'h11223344, 4'hF);
        issue(0, 1'b1, 3, 32'hAABBCCDD, 4'h5);
        issue(0, 1'b0, 3, 32'h0, 4'h0);
        wait_cyc(3);
        chk("be_merge", 64'(rd_a[31:0]), 64'h11BB33DD);
        chk("model_mm3", 64'(mm[3]), 64'h11BB33DD);
        issue(0, 1'b1, 7, 32'hFFFFFFFF, 4'h0);
        issue(1, 1'b0, 50, 32'h0, 4'h0);
        wait_cyc(3);
        chk("oor_rd_err", 64'(err_a[1]), 64'(1));
        chk("oor_rd_data", 64'(rd_a[63:32]), 64'(0));
        issue(1, 1'b1, 48, 32'h12345678, 4'hF);
        issue(1, 1'b0, 63, 32'h0, 4'h0);
        wait_cyc(3);
        chk("oor_err_b", 64'(err_b[1]), 64'(1));
        for (int a = 0; a < D; a++) issue(0, 1'b0, a, 32'h0, 4'h0);
        issue(1, 1'b0, 4, 32'h0, 4'h0);
        rst_n = 1'b0;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(3);
        chk("post_rst_rv", 64'(rv_a), 64'(0));
        chk("post_rst_rd", rd_a, 64'(0));
        valid = 2'b11;
        wr = 2'b00;
        addr = {6'd2, 6'd1};
        @(negedge clk_i);
        chk("post_rst_grant", 64'(ready_a), 64'h1);
        @(posedge clk_i);
        #1;
        valid[0] = 1'b0;
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
        valid[1] = 1'b0;
        n0 = cnt_b0;
        for (int i = 0; i < 16; i++) issue(0, 1'b0, int'($urandom_range(0, D - 1)), 32'h0, 4'h0);
        wait_cyc(3);
        chk("burst_count", 64'(cnt_b0 - n0), 64'(16));
        for (int n = 0; n < 400; n++) begin
            @(negedge clk_i);
            rdy_s = ready_a;
            @(posedge clk_i);
            #1;
            for (int c = 0; c < NC; c++)
                if (!valid[c] || rdy_s[c]) begin
                    valid[c] = ($urandom_range(0, 2) != 0);
                    wr[c] = 1'($urandom_range(0, 1));
                    addr[c*AW +: AW] = 6'($urandom_range(0, 55));
                    wdata[c*W +: W] = $urandom;
                    be[c*NBY +: NBY] = 4'($urandom);
                end
        end
        @(negedge clk_i);
        rdy_s = ready_a;
        @(posedge clk_i);
        #1;
        valid = '0;
        for (int a = 0; a < D; a++) issue(1, 1'b0, a, 32'h0, 4'h0);
        wait_cyc(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
